// File: rtl/ram_rd_arbiter_pkg.sv
// Shared constants, helpers and types for the ram_rd_arbiter slice.
// The optional ARB_LOCK_EN macro is consumed by the interface, top and bench.
package ram_arb_pkg;

    localparam int unsigned DEF_NREQ   = 2;
    localparam int unsigned DEF_ADDR_W = 2;
    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned DEF_ID_W   = 1;

    // Minimum bits needed to encode n distinct values.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(n)) begin
            r++;
        end
        return r;
    endfunction

    typedef struct packed {
        logic                  valid;
        logic [DEF_ID_W-1:0]   id;
        logic [DEF_DATA_W-1:0] data;
    } rsp_t;

endpackage

// File: rtl/ram_rd_arbiter_if.sv
// Requester/RAM bus shared by the read arbiter and its clients.
// Optional macro ARB_LOCK_EN adds the per-requester lock vector.
interface ram_rd_arbiter_if #(
    parameter int unsigned NREQ   = 2,
    parameter int unsigned ADDR_W = 2,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ID_W   = 1
);

    logic [NREQ-1:0]        req;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ-1:0]        gnt;
`ifdef ARB_LOCK_EN
    logic [NREQ-1:0]        lock;
`endif
    logic [ADDR_W-1:0]      ram_addr_rd;
    logic [DATA_W-1:0]      ram_data_rd;
    logic                   rsp_valid;
    logic [ID_W-1:0]        rsp_id;
    logic [DATA_W-1:0]      rsp_data;
    logic                   busy;

    // Arbiter side.
    modport slave (
        input  req,
        input  req_addr,
`ifdef ARB_LOCK_EN
        input  lock,
`endif
        input  ram_data_rd,
        output gnt,
        output ram_addr_rd,
        output rsp_valid,
        output rsp_id,
        output rsp_data,
        output busy
    );

    // Requester/RAM side.
    modport master (
        output req,
        output req_addr,
`ifdef ARB_LOCK_EN
        output lock,
`endif
        output ram_data_rd,
        input  gnt,
        input  ram_addr_rd,
        input  rsp_valid,
        input  rsp_id,
        input  rsp_data,
        input  busy
    );

endinterface

// File: rtl/ram_rd_arbiter_rr_pick.sv
// Combinational round-robin picker: searches ptr+1, ptr+2, ... modulo NREQ,
// or re-selects ptr outright when the current owner holds a lock.
module rr_pick #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned ID_W = 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [ID_W-1:0] ptr_i,
    input  logic            lock_hit_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [ID_W-1:0] winner_o
);

    logic        found;
    int unsigned idx;

    always_comb begin
        gnt_o    = '0;
        winner_o = ptr_i;
        found    = 1'b0;
        idx      = 0;
        if (lock_hit_i) begin
            gnt_o[ptr_i] = 1'b1;
        end else begin
            for (int unsigned k = 1; k <= NREQ; k++) begin
                idx = (32'(ptr_i) + k) % NREQ;
                if (!found && req_i[idx]) begin
                    found      = 1'b1;
                    gnt_o[idx] = 1'b1;
                    winner_o   = ID_W'(idx);
                end
            end
        end
    end

endmodule

// File: rtl/ram_rd_arbiter.sv
// Round-robin arbiter sharing one combinational RAM read port between NREQ
// requesters; 2-cycle pipelined tagged response. ARB_LOCK_EN enables lock.
module ram_rd_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned NREQ   = DEF_NREQ,
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ID_W   = DEF_ID_W
) (
    input logic              clk,
    input logic              rst_n,
    ram_rd_arbiter_if.slave  bus
);

    if (NREQ < 1 || NREQ > 8 || ID_W < clog2(NREQ) || ID_W < 1) begin : g_bad_cfg
        $error("ram_rd_arbiter: NREQ must be 1..8 and 2**ID_W >= NREQ");
    end

    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic              s1_vld_q, s1_vld_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

    logic [NREQ-1:0]   pick_gnt;
    logic [ID_W-1:0]   win;
    logic              lock_hit;
    logic              accept;
    logic [ADDR_W-1:0] addr_sel;

`ifdef ARB_LOCK_EN
    assign lock_hit = bus.req[ptr_q] & bus.lock[ptr_q];
`else
    assign lock_hit = 1'b0;
`endif

    rr_pick #(
        .NREQ (NREQ),
        .ID_W (ID_W)
    ) u_rr_pick (
        .req_i      (bus.req),
        .ptr_i      (ptr_q),
        .lock_hit_i (lock_hit),
        .gnt_o      (pick_gnt),
        .winner_o   (win)
    );

    // Grants are suppressed while reset is held so nothing is accepted.
    assign bus.gnt = rst_n ? pick_gnt : '0;
    assign accept  = |bus.gnt;

    always_comb begin
        addr_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win == ID_W'(i)) begin
                addr_sel = bus.req_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    always_comb begin
        ptr_d       = ptr_q;
        addr_d      = addr_q;
        id_d        = id_q;
        s1_vld_d    = accept;
        rsp_valid_d = s1_vld_q;
        rsp_id_d    = id_q;
        rsp_data_d  = rsp_data_q;
        if (accept) begin
            ptr_d  = win;
            addr_d = addr_sel;
            id_d   = win;
        end
        if (s1_vld_q) begin
            rsp_data_d = bus.ram_data_rd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q       <= ID_W'(NREQ - 1);
            addr_q      <= '0;
            id_q        <= '0;
            s1_vld_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
        end else begin
            ptr_q       <= ptr_d;
            addr_q      <= addr_d;
            id_q        <= id_d;
            s1_vld_q    <= s1_vld_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign bus.ram_addr_rd = addr_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_id      = rsp_id_q;
    assign bus.rsp_data    = rsp_data_q;
    assign bus.busy        = s1_vld_q | rsp_valid_q;

endmodule

// File: tb/tb_ram_rd_arbiter.sv
// Self-checking bench for ram_rd_arbiter: grant vectors plus a response
// scoreboard keyed on the cycle each response is due.
module tb_ram_rd_arbiter;
    import ram_arb_pkg::*;

    localparam int unsigned NREQ   = 2;
    localparam int unsigned ADDR_W = 2;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned ID_W   = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ram_rd_arbiter_if #(
        .NREQ   (NREQ),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .ID_W   (ID_W)
    ) bus ();

    ram_rd_arbiter #(
        .NREQ   (NREQ),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .ID_W   (ID_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [DATA_W-1:0] mem [4] = '{8'h11, 8'h22, 8'h33, 8'hAA};
    assign bus.ram_data_rd = mem[bus.ram_addr_rd];

    typedef struct {
        int unsigned       due;
        logic [ID_W-1:0]   id;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } exp_t;

    typedef struct {
        logic [1:0]        req;
        logic [ADDR_W-1:0] a0;
        logic [ADDR_W-1:0] a1;
        logic [1:0]        gnt;
    } vec_t;

    exp_t              sbq[$];
    int unsigned       cyc = 0;
    int                errors = 0;
    int                checks = 0;
    logic [ADDR_W-1:0] exp_raddr = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Response-side monitor.
    always @(negedge clk) begin : mon
        logic exp_busy;
        exp_t e;
        exp_busy = 1'b0;
        foreach (sbq[i]) begin
            if (sbq[i].due == cyc + 1) exp_raddr = sbq[i].addr;
            if (sbq[i].due == cyc || sbq[i].due == cyc + 1) exp_busy = 1'b1;
        end
        check("ram_addr_rd", 32'(bus.ram_addr_rd), 32'(exp_raddr));
        check("busy", 32'(bus.busy), 32'(exp_busy));
        if (sbq.size() > 0 && sbq[0].due == cyc) begin
            e = sbq.pop_front();
            check("rsp_valid", 32'(bus.rsp_valid), 32'd1);
            check("rsp_id", 32'(bus.rsp_id), 32'(e.id));
            check("rsp_data", 32'(bus.rsp_data), 32'(e.data));
        end else begin
            check("rsp_valid_idle", 32'(bus.rsp_valid), 32'd0);
        end
    end

    // One cycle of stimulus; the expected grant also fixes the scoreboard entry.
    task automatic step(input logic [1:0] r, input logic [ADDR_W-1:0] a0,
                        input logic [ADDR_W-1:0] a1, input logic [1:0] exp_g,
                        input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        bus.req      = r;
        bus.req_addr = {a1, a0};
        @(negedge clk);
        check(nm, 32'(bus.gnt), 32'(exp_g));
        if (exp_g != 2'b00) begin
            e.due  = cyc + 2;
            e.id   = exp_g[1] ? 1'b1 : 1'b0;
            e.addr = exp_g[1] ? a1 : a0;
            e.data = mem[e.addr];
            sbq.push_back(e);
        end
    endtask

    task automatic reset_dut();
        @(posedge clk);
        #1;
        rst_n     = 1'b0;
        bus.req   = '0;
        sbq.delete();
        exp_raddr = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    vec_t vecs[13];

    initial begin
        vecs[0]  = '{2'b00, 2'd0, 2'd0, 2'b00};
        vecs[1]  = '{2'b01, 2'd2, 2'd0, 2'b01};
        vecs[2]  = '{2'b00, 2'd1, 2'd1, 2'b00};
        vecs[3]  = '{2'b11, 2'd1, 2'd3, 2'b10};
        vecs[4]  = '{2'b11, 2'd0, 2'd2, 2'b01};
        vecs[5]  = '{2'b11, 2'd3, 2'd1, 2'b10};
        vecs[6]  = '{2'b11, 2'd2, 2'd0, 2'b01};
        vecs[7]  = '{2'b10, 2'd3, 2'd0, 2'b10};
        vecs[8]  = '{2'b10, 2'd2, 2'd1, 2'b10};
        vecs[9]  = '{2'b01, 2'd1, 2'd3, 2'b01};
        vecs[10] = '{2'b01, 2'd3, 2'd2, 2'b01};
        vecs[11] = '{2'b11, 2'd2, 2'd3, 2'b10};
        vecs[12] = '{2'b00, 2'd0, 2'd0, 2'b00};

        bus.req      = '0;
        bus.req_addr = '0;
`ifdef ARB_LOCK_EN
        bus.lock     = '0;
`endif
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        repeat (10) step(2'b00, 2'd0, 2'd0, 2'b00, "idle_gnt");

        step(2'b01, 2'd2, 2'd0, 2'b01, "single_gnt");
        repeat (3) step(2'b00, 2'd0, 2'd0, 2'b00, "single_tail");

        reset_dut();
        for (int i = 0; i < 6; i++) begin
            step(2'b11, 2'd1, 2'd3, (i % 2 == 0) ? 2'b01 : 2'b10, "rr_gnt");
        end
        repeat (3) step(2'b00, 2'd0, 2'd0, 2'b00, "rr_tail");

        for (int i = 0; i < 4; i++) begin
            step(2'b10, 2'd0, ADDR_W'(i), 2'b10, "solo1_gnt");
        end
        repeat (3) step(2'b00, 2'd0, 2'd0, 2'b00, "solo1_tail");

        // Accepted request is in flight when reset hits; it must vanish.
        step(2'b01, 2'd3, 2'd0, 2'b01, "pre_rst_gnt");
        reset_dut();
        repeat (2) step(2'b00, 2'd0, 2'd0, 2'b00, "post_rst_idle");
        step(2'b11, 2'd0, 2'd1, 2'b01, "post_rst_gnt");
        repeat (3) step(2'b00, 2'd0, 2'd0, 2'b00, "post_rst_tail");

        reset_dut();
        for (int i = 0; i < 13; i++) begin
            step(vecs[i].req, vecs[i].a0, vecs[i].a1, vecs[i].gnt, $sformatf("vec%0d_gnt", i));
        end
        repeat (3) step(2'b00, 2'd0, 2'd0, 2'b00, "vec_tail");

`ifdef ARB_LOCK_EN
        reset_dut();
        bus.lock = 2'b01;
        repeat (3) step(2'b11, 2'd1, 2'd2, 2'b01, "lock_gnt");
        bus.lock = 2'b00;
        step(2'b11, 2'd1, 2'd2, 2'b10, "unlock_gnt");
        repeat (3) step(2'b00, 2'd0, 2'd0, 2'b00, "lock_tail");
`endif

        repeat (2) step(2'b00, 2'd0, 2'd0, 2'b00, "drain");
        check("sb_drained", 32'(sbq.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
